// File: rtl/parking_gate_controller.sv
// Entry-lane gate controller: password check with retry lockout, lot occupancy
// tracking and a directly driven LED / two-digit seven-segment indicator panel.
module parking_gate_controller #(
  parameter int unsigned         PW_WIDTH       = 2,
  parameter logic [PW_WIDTH-1:0] PASSWORD_1     = 2'b01,
  parameter logic [PW_WIDTH-1:0] PASSWORD_2     = 2'b10,
  parameter int unsigned         CAPACITY       = 8,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter int unsigned         TIMEOUT_CYCLES = 16,
  parameter int unsigned         LOCK_CYCLES    = 16,
  parameter int unsigned         BLINK_DIV      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             Front_Sensor,
  input  logic                             Back_Sensor,
  input  logic                             Exit_Sensor,
  input  logic [PW_WIDTH-1:0]              password_1,
  input  logic [PW_WIDTH-1:0]              password_2,
  input  logic                             pass_valid,
  output logic                             GREEN_LED,
  output logic                             RED_LED,
  output logic [6:0]                       HEX_1,
  output logic [6:0]                       HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]    occupancy,
  output logic                             full
);

  localparam int unsigned OCC_W   = $clog2(CAPACITY + 1);
  localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int unsigned WAIT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_N   = 7'b0101011;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_P   = 7'b0001100;

  typedef enum logic [2:0] {
    IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, LOCKOUT
  } state_t;

  state_t              state, state_next;
  logic [TRY_W-1:0]    tries, tries_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink;
  logic                entry_c;
  logic                pw_correct_c, pw_wrong_c;
  logic [6:0]          hex1_c, hex2_c;
  logic                green_c, red_c;

  assign pw_correct_c = pass_valid && (password_1 == PASSWORD_1) && (password_2 == PASSWORD_2);
  assign pw_wrong_c   = pass_valid && !pw_correct_c;
  assign full         = (occupancy == OCC_W'(CAPACITY));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, retry bookkeeping and entry detection.
  always_comb begin
    state_next = state;
    tries_next = tries;
    entry_c    = 1'b0;
    case (state)
      IDLE: if (Front_Sensor && !full) state_next = WAIT_PASSWORD;
      WAIT_PASSWORD, WRONG_PASS, STOP: begin
        if (pw_correct_c) begin
          state_next = RIGHT_PASS;
          tries_next = '0;
        end else if (pw_wrong_c) begin
          tries_next = tries + TRY_W'(1);
          if (tries_next == TRY_W'(MAX_TRIES)) state_next = LOCKOUT;
          else if (state != STOP)             state_next = WRONG_PASS;
        end else if (state == WAIT_PASSWORD && wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = IDLE;
          tries_next = '0;
        end
      end
      RIGHT_PASS: begin
        if (Front_Sensor && Back_Sensor) begin
          state_next = STOP;
        end else if (Back_Sensor) begin
          state_next = IDLE;
          entry_c    = 1'b1;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_next = IDLE;
          tries_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Panel decode of the current state; registered below.
  always_comb begin
    hex1_c  = SEG_OFF;
    hex2_c  = SEG_OFF;
    green_c = 1'b0;
    red_c   = 1'b0;
    case (state)
      IDLE: if (full) begin hex1_c = SEG_F; hex2_c = SEG_L; red_c = 1'b1; end
      WAIT_PASSWORD: begin hex1_c = SEG_E; hex2_c = SEG_N; red_c = 1'b1; end
      WRONG_PASS:    begin hex1_c = SEG_E; hex2_c = SEG_E; red_c = blink; end
      RIGHT_PASS:    begin hex1_c = SEG_6; hex2_c = SEG_0; green_c = blink; end
      STOP:          begin hex1_c = SEG_5; hex2_c = SEG_P; red_c = blink; end
      LOCKOUT:       begin hex1_c = SEG_L; hex2_c = SEG_0; red_c = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HEX_1     <= SEG_OFF;
      HEX_2     <= SEG_OFF;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
    end else begin
      HEX_1     <= hex1_c;
      HEX_2     <= hex2_c;
      GREEN_LED <= green_c;
      RED_LED   <= red_c;
    end
  end

  // Counters restart whenever their state is (re)entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      tries     <= '0;
      wait_cnt  <= '0;
      lock_cnt  <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      tries    <= tries_next;
      wait_cnt <= (state == WAIT_PASSWORD && state_next == WAIT_PASSWORD) ?
                  wait_cnt + WAIT_W'(1) : '0;
      lock_cnt <= (state == LOCKOUT && state_next == LOCKOUT) ?
                  lock_cnt + LOCK_W'(1) : '0;
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Simultaneous entry and exit cancel; both directions saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else if (entry_c && !Exit_Sensor) begin
      if (!full) occupancy <= occupancy + OCC_W'(1);
    end else if (Exit_Sensor && !entry_c) begin
      if (occupancy != '0) occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Scoreboard bench for parking_gate_controller (CAPACITY=2, other parameters default).
module tb_parking_gate_controller;

  localparam int unsigned CAP  = 2;
  localparam int unsigned MAXT = 3;
  localparam int unsigned TO   = 16;
  localparam int unsigned LC   = 16;
  localparam int unsigned BD   = 4;
  localparam int unsigned OW   = $clog2(CAP + 1);

  localparam logic [6:0] S_OFF = 7'h7F, S_F = 7'b0001110, S_L = 7'b1000111,
                         S_E = 7'b0000110, S_N = 7'b0101011, S_6 = 7'b0000010,
                         S_0 = 7'b1000000, S_5 = 7'b0010010, S_P = 7'b0001100;

  localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_RIGHT = 3, M_STOP = 4, M_LOCK = 5;

  logic          clk = 1'b0;
  logic          reset, front, back, exit_s, pv;
  logic [1:0]    pw1, pw2;
  logic          green, red, full;
  logic [6:0]    hex1, hex2;
  logic [OW-1:0] occ;

  typedef struct packed {
    logic [6:0]    hex1;
    logic [6:0]    hex2;
    logic          green;
    logic          red;
    logic [OW-1:0] occ;
    logic          full;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  int   m_state, m_occ, m_tries, m_wait, m_lock, m_bcnt;
  bit   m_blink;
  exp_t m_out;

  parking_gate_controller #(
    .PW_WIDTH(2), .PASSWORD_1(2'b01), .PASSWORD_2(2'b10), .CAPACITY(CAP),
    .MAX_TRIES(MAXT), .TIMEOUT_CYCLES(TO), .LOCK_CYCLES(LC), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .reset(reset), .Front_Sensor(front), .Back_Sensor(back),
    .Exit_Sensor(exit_s), .password_1(pw1), .password_2(pw2), .pass_valid(pv),
    .GREEN_LED(green), .RED_LED(red), .HEX_1(hex1), .HEX_2(hex2),
    .occupancy(occ), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: advances one clock edge using the currently driven inputs.
  task automatic model_step();
    bit corr, wrong, entry;
    int nxt;
    if (reset) begin
      m_state = M_IDLE; m_occ = 0; m_tries = 0; m_wait = 0; m_lock = 0;
      m_bcnt = 0; m_blink = 0;
      m_out.hex1 = S_OFF; m_out.hex2 = S_OFF; m_out.green = 0; m_out.red = 0;
    end else begin
      m_out.green = 0; m_out.red = 0; m_out.hex1 = S_OFF; m_out.hex2 = S_OFF;
      case (m_state)
        M_IDLE:  if (m_occ == CAP) begin m_out.hex1 = S_F; m_out.hex2 = S_L; m_out.red = 1; end
        M_WAIT:  begin m_out.hex1 = S_E; m_out.hex2 = S_N; m_out.red = 1; end
        M_WRONG: begin m_out.hex1 = S_E; m_out.hex2 = S_E; m_out.red = m_blink; end
        M_RIGHT: begin m_out.hex1 = S_6; m_out.hex2 = S_0; m_out.green = m_blink; end
        M_STOP:  begin m_out.hex1 = S_5; m_out.hex2 = S_P; m_out.red = m_blink; end
        default: begin m_out.hex1 = S_L; m_out.hex2 = S_0; m_out.red = 1; end
      endcase
      corr  = pv && pw1 == 2'b01 && pw2 == 2'b10;
      wrong = pv && !corr;
      nxt   = m_state;
      entry = 0;
      if (m_state == M_IDLE) begin
        if (front && m_occ != CAP) nxt = M_WAIT;
      end else if (m_state == M_RIGHT) begin
        if (front && back) nxt = M_STOP;
        else if (back) begin nxt = M_IDLE; entry = 1; end
      end else if (m_state == M_LOCK) begin
        if (m_lock == LC - 1) begin nxt = M_IDLE; m_tries = 0; end
      end else begin
        if (corr) begin nxt = M_RIGHT; m_tries = 0; end
        else if (wrong) begin
          m_tries = m_tries + 1;
          if (m_tries == MAXT) nxt = M_LOCK;
          else if (m_state != M_STOP) nxt = M_WRONG;
        end else if (m_state == M_WAIT && m_wait == TO - 1) begin
          nxt = M_IDLE; m_tries = 0;
        end
      end
      m_wait = (m_state == M_WAIT && nxt == M_WAIT) ? m_wait + 1 : 0;
      m_lock = (m_state == M_LOCK && nxt == M_LOCK) ? m_lock + 1 : 0;
      if (entry && !exit_s) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
      else if (exit_s && !entry) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
      if (m_bcnt == BD - 1) begin m_bcnt = 0; m_blink = !m_blink; end
      else m_bcnt = m_bcnt + 1;
      m_state = nxt;
    end
    m_out.occ  = OW'(m_occ);
    m_out.full = (m_occ == CAP);
  endtask

  // Push the expectation for this edge, clock once, then pop and compare.
  task automatic step();
    exp_t e;
    model_step();
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("HEX_1", 32'(hex1), 32'(e.hex1));
    check("HEX_2", 32'(hex2), 32'(e.hex2));
    check("GREEN_LED", 32'(green), 32'(e.green));
    check("RED_LED", 32'(red), 32'(e.red));
    check("occupancy", 32'(occ), 32'(e.occ));
    check("full", 32'(full), 32'(e.full));
  endtask

  task automatic drive(input logic f, input logic b, input logic x,
                       input logic v, input logic [1:0] p1, input logic [1:0] p2);
    front = f; back = b; exit_s = x; pv = v; pw1 = p1; pw2 = p2;
    step();
    front = 0; back = 0; exit_s = 0; pv = 0; pw1 = 0; pw2 = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic submit_ok();  drive(0, 0, 0, 1, 2'b01, 2'b10); endtask
  task automatic submit_bad(); drive(0, 0, 0, 1, 2'b00, 2'b00); endtask
  task automatic arrive();     drive(1, 0, 0, 0, 2'b00, 2'b00); endtask

  initial begin
    reset = 1; front = 0; back = 0; exit_s = 0; pv = 0; pw1 = 0; pw2 = 0;
    step(); step();
    reset = 0;
    check("rst_hex1", 32'(hex1), 32'h7F);
    check("rst_hex2", 32'(hex2), 32'h7F);
    check("rst_leds", 32'({green, red}), 32'd0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_full", 32'(full), 32'd0);

    // correct entry, green blinks, car parks
    arrive(); submit_ok(); idle(10);
    drive(0, 1, 0, 0, 2'b00, 2'b00);
    check("entry_occ", 32'(occ), 32'd1);

    // three wrong tries, correct one ignored during lockout
    arrive(); submit_bad(); idle(1); submit_bad(); submit_bad();
    submit_ok();
    check("lock_hex1", 32'(hex1), 32'(S_L));
    check("lock_red", 32'(red), 32'd1);
    idle(18);
    check("lock_exit_hex", 32'(hex1), 32'h7F);
    arrive(); idle(1);
    check("fresh_wait", 32'(hex1), 32'(S_E));
    idle(15);

    // tailgate then recovery; lot becomes full
    arrive(); submit_ok();
    drive(1, 1, 0, 0, 2'b00, 2'b00);
    idle(6);
    check("stop_occ", 32'(occ), 32'd1);
    submit_ok();
    drive(0, 1, 0, 0, 2'b00, 2'b00);
    check("full_flag", 32'(full), 32'd1);
    idle(1);
    check("full_hex1", 32'(hex1), 32'(S_F));
    arrive(); arrive(); arrive();
    check("full_stay", 32'(hex2), 32'(S_L));

    drive(0, 0, 1, 0, 2'b00, 2'b00);
    check("exit_occ", 32'(occ), 32'd1);
    arrive(); submit_ok();
    drive(0, 1, 1, 0, 2'b00, 2'b00);
    check("inout_occ", 32'(occ), 32'd1);
    drive(0, 0, 1, 0, 2'b00, 2'b00);
    drive(0, 0, 1, 0, 2'b00, 2'b00);
    check("exit_sat", 32'(occ), 32'd0);

    // timeout at entry edge + 16, then submission in last cycle wins
    arrive(); idle(16);
    check("to_edge_hex", 32'(hex1), 32'(S_E));
    idle(1);
    check("to_idle_hex", 32'(hex1), 32'h7F);
    arrive(); idle(15); submit_ok(); idle(1);
    check("to_boundary", 32'(hex1), 32'(S_6));
    drive(0, 1, 0, 0, 2'b00, 2'b00);

    // reset during lockout discards count and lockout
    arrive(); submit_bad(); submit_bad(); submit_bad(); idle(3);
    reset = 1; step(); reset = 0;
    check("midrst_occ", 32'(occ), 32'd0);
    check("midrst_hex", 32'(hex1), 32'h7F);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic f, b, x, v;
      logic [1:0] p1, p2;
      f = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 9) < 2);
      x = ($urandom_range(0, 9) < 1);
      v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin p1 = 2'b01; p2 = 2'b10; end
      else begin p1 = 2'($urandom); p2 = 2'($urandom); end
      reset = ($urandom_range(0, 99) == 0);
      drive(f, b, x, v, p1, p2);
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
